// File: rtl/waveform_writer_if.sv
// Scope-writer bus: the audio sample stream in, and the renderer's column read port.
// sample_valid is a one-cycle strobe with no ready: the writer always takes it.
// rd_x is sampled every clock, and next_val answers it one clock later.
interface waveform_writer_if;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [9:0]  rd_x;
  logic [9:0]  next_val;
  logic        frame_ready;
  logic        overrun;

  modport master (
    output sample_valid, sample_in, rd_x,
    input  next_val, frame_ready, overrun
  );

  modport slave (
    input  sample_valid, sample_in, rd_x,
    output next_val, frame_ready, overrun
  );
endinterface

// File: rtl/waveform_writer.sv
// Decimates audio samples into a ping-pong column buffer for the scope renderer.
// The banks swap only on a synchronized frame_clk rising edge, so a frame never shows a torn trace.
module waveform_writer #(
  parameter int NUM_COLS = 640,
  parameter int DECIM    = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  waveform_writer_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [DEC_W-1:0] LAST_DEC = DEC_W'(DECIM - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             bank_sel_q, bank_sel_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             frame_ready_q, frame_ready_d;
  logic             overrun_q, overrun_d;
  logic             wr_en;
  logic [2:0]       fc_sync;
  logic             frame_edge;
  logic [7:0]       val8;
  logic             col_done;
  logic             last_write;
  logic             rd_hit;
  logic [COL_W-1:0] rd_idx;
  logic             unused_low;
  logic [7:0]       mem_a [NUM_COLS];
  logic [7:0]       mem_b [NUM_COLS];

  // Two flops to synchronize, a third to find the rising edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) fc_sync <= 3'b000;
    else        fc_sync <= {fc_sync[1:0], frame_clk};
  end
  assign frame_edge = fc_sync[1] & ~fc_sync[2];

  assign val8       = bus.sample_in[15:8] ^ 8'h80;
  assign unused_low = ^bus.sample_in[7:0];
  assign col_done   = bus.sample_valid && (dec_cnt_q == LAST_DEC);
  assign last_write = (state_q == FILL) && col_done && (wr_col_q == LAST_COL);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      bank_sel_q    <= 1'b0;
      wr_col_q      <= '0;
      dec_cnt_q     <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_sel_q    <= bank_sel_d;
      wr_col_q      <= wr_col_d;
      dec_cnt_q     <= dec_cnt_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    wr_col_d      = wr_col_q;
    dec_cnt_d     = dec_cnt_q;
    frame_ready_d = frame_ready_q;
    overrun_d     = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          state_d   = FILL;
          wr_col_d  = '0;
          dec_cnt_d = '0;
        end
      end
      FILL: begin
        if (frame_edge) begin
          // A frame edge always restarts at column 0; it publishes only if this cycle completes the bank.
          wr_col_d  = '0;
          dec_cnt_d = '0;
          if (last_write) begin
            wr_en         = 1'b1;
            bank_sel_d    = ~bank_sel_q;
            frame_ready_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (bus.sample_valid) begin
          if (col_done) begin
            wr_en     = 1'b1;
            dec_cnt_d = '0;
            if (wr_col_q == LAST_COL) begin
              state_d  = DONE;
              wr_col_d = '0;
            end else begin
              wr_col_d = wr_col_q + COL_W'(1);
            end
          end else begin
            dec_cnt_d = dec_cnt_q + DEC_W'(1);
          end
        end
      end
      DONE: begin
        if (frame_edge) begin
          state_d       = FILL;
          bank_sel_d    = ~bank_sel_q;
          frame_ready_d = 1'b1;
          wr_col_d      = '0;
          dec_cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes go to the bank the renderer is not reading: bank_sel=0 shows mem_a.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (bank_sel_q) mem_a[wr_col_q] <= val8;
      else            mem_b[wr_col_q] <= val8;
    end
  end

  assign rd_hit = frame_ready_q && (int'(bus.rd_x) < NUM_COLS);
  assign rd_idx = bus.rd_x[COL_W-1:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      bus.next_val <= '0;
    else if (rd_hit) bus.next_val <= {2'b00, (bank_sel_q ? mem_b[rd_idx] : mem_a[rd_idx])};
    else             bus.next_val <= '0;
  end

  assign bus.frame_ready = frame_ready_q;
  assign bus.overrun     = overrun_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_waveform_writer.sv
// Bench for waveform_writer: two instances (DECIM=2 and DECIM=1, 8 columns) share one stimulus
// and are checked every cycle against a sample-counting model, plus directed corner sequences.
module tb_waveform_writer;
  localparam int NC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fclk = 1'b0;
  logic        sv = 1'b0;
  logic [15:0] si = '0;
  logic [9:0]  rdx = '0;
  logic [1:0]  dbg0, dbg1;

  waveform_writer_if bus0();
  waveform_writer_if bus1();

  assign bus0.sample_valid = sv;
  assign bus0.sample_in    = si;
  assign bus0.rd_x         = rdx;
  assign bus1.sample_valid = sv;
  assign bus1.sample_in    = si;
  assign bus1.rd_x         = rdx;

  waveform_writer #(.NUM_COLS(NC), .DECIM(2)) dut0 (
    .Clk(clk), .Reset(rst_n), .frame_clk(fclk), .bus(bus0.slave), .dbg_state(dbg0)
  );
  waveform_writer #(.NUM_COLS(NC), .DECIM(1)) dut1 (
    .Clk(clk), .Reset(rst_n), .frame_clk(fclk), .bus(bus1.slave), .dbg_state(dbg1)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counts accepted samples since the fill started; column c is the sample
  // whose count is (c+1)*DECIM. A bank is published only when all NC*DECIM samples are in.
  int         decim [2] = '{2, 1};
  bit         armed [2];
  bit         ready [2];
  int         n_smp [2];
  logic [7:0] pub   [2][NC];
  logic [7:0] pend  [2][NC];
  bit         hist  [4];
  logic [11:0] exp_q[$];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b0;
      ready[d] = 1'b0;
      n_smp[d] = 0;
    end
    for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit         edge_now;
    logic [7:0] v8;
    logic [9:0] nv;
    bit         ov;
    int         full;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = fclk;
    // frame_clk seen high two clocks ago and low the clock before that
    edge_now = hist[2] && !hist[3];
    v8 = si[15:8] ^ 8'h80;
    for (int d = 0; d < 2; d++) begin
      full = NC * decim[d];
      nv = 10'd0;
      ov = 1'b0;
      if (ready[d] && rdx < NC) nv = {2'b00, pub[d][rdx]};
      if (edge_now) begin
        if (!armed[d]) begin
          armed[d] = 1'b1;
        end else begin
          if (sv && n_smp[d] == full - 1) begin
            pend[d][NC-1] = v8;
            n_smp[d] = full;
          end
          if (n_smp[d] == full) begin
            for (int c = 0; c < NC; c++) pub[d][c] = pend[d][c];
            ready[d] = 1'b1;
          end else begin
            ov = 1'b1;
          end
        end
        n_smp[d] = 0;
      end else if (armed[d] && sv && n_smp[d] < full) begin
        n_smp[d]++;
        if (n_smp[d] % decim[d] == 0) pend[d][n_smp[d] / decim[d] - 1] = v8;
      end
      exp_q.push_back({ov, ready[d], nv});
    end
  endfunction

  task automatic compare_outputs();
    logic [11:0] e;
    e = exp_q.pop_front();
    check("next_val0", bus0.next_val, e[9:0]);
    check("frame_ready0", bus0.frame_ready, e[10]);
    check("overrun0", bus0.overrun, e[11]);
    e = exp_q.pop_front();
    check("next_val1", bus1.next_val, e[9:0]);
    check("frame_ready1", bus1.frame_ready, e[10]);
    check("overrun1", bus1.overrun, e[11]);
  endtask

  // driver: one clock with the given inputs, then model and compare #1 after the edge
  task automatic cycle(input bit v, input logic [15:0] s, input logic [9:0] x);
    sv = v;
    si = s;
    rdx = x;
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic frame_pulse();
    fclk = 1'b1;
    repeat (3) cycle(1'b0, 16'h0, rdx);
    fclk = 1'b0;
    cycle(1'b0, 16'h0, rdx);
  endtask

  task automatic reset_mid();
    fclk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_next_val0", bus0.next_val, 10'd0);
    check("rst_frame_ready0", bus0.frame_ready, 1'b0);
    check("rst_overrun0", bus0.overrun, 1'b0);
    check("rst_frame_ready1", bus1.frame_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] sample;
    logic [7:0]  val;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int ov_cnt0, ov_cnt1, half, left;
    tbl[0] = '{16'h7FFF, 8'hFF};
    tbl[1] = '{16'h8000, 8'h00};
    tbl[2] = '{16'h0000, 8'h80};
    tbl[3] = '{16'hFFFF, 8'h7F};
    tbl[4] = '{16'h1234, 8'h92};
    tbl[5] = '{16'hABCD, 8'h2B};
    tbl[6] = '{16'h0100, 8'h81};
    tbl[7] = '{16'hFF00, 8'h7F};

    // power-on reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("por_next_val0", bus0.next_val, 10'd0);
    check("por_frame_ready0", bus0.frame_ready, 1'b0);
    check("por_overrun0", bus0.overrun, 1'b0);
    rst_n = 1'b1;

    // reset in the middle of a fill
    frame_pulse();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 10'd3);
    reset_mid();
    cycle(1'b0, 16'h0, 10'd3);
    check("t1_next_val", bus0.next_val, 10'd0);
    check("t1_frame_ready", bus0.frame_ready, 1'b0);
    check("t1_overrun", bus0.overrun, 1'b0);

    // fill and swap
    frame_pulse();
    for (int k = 0; k < 16; k++) cycle(1'b1, 16'(k * 16'h1000), 10'd0);
    frame_pulse();
    check("t2_frame_ready", bus0.frame_ready, 1'b1);
    for (int c = 0; c < NC; c++) begin
      cycle(1'b0, 16'h0, 10'(c));
      check("t2_col", bus0.next_val, 10'(((2 * c + 1) * 16) ^ 8'h80));
    end

    // conversion table through the DECIM=1 instance
    frame_pulse();
    for (int i = 0; i < 8; i++) cycle(1'b1, tbl[i].sample, 10'd0);
    frame_pulse();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'h0, 10'(i));
      check("t3_conv", bus1.next_val, {2'b00, tbl[i].val});
    end

    // overrun: short frame, read bank must keep the earlier frame
    frame_pulse();
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'($urandom), 10'd0);
    ov_cnt0 = 0;
    ov_cnt1 = 0;
    fclk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0, 10'd0);
      ov_cnt0 += int'(bus0.overrun);
      ov_cnt1 += int'(bus1.overrun);
    end
    check("t4_overrun_pulses0", ov_cnt0, 1);
    check("t4_overrun_pulses1", ov_cnt1, 1);
    for (int c = 0; c < NC; c++) begin
      cycle(1'b0, 16'h0, 10'(c));
      check("t4_bank_kept", bus0.next_val, 10'(((2 * c + 1) * 16) ^ 8'h80));
    end

    // frame edge lands on the cycle of the 16th valid
    fclk = 1'b0;
    repeat (2) cycle(1'b0, 16'h0, 10'd0);
    ov_cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 13) fclk = 1'b1;
      cycle(1'b1, (i == 15) ? 16'h5A00 : 16'(i * 16'h0300), 10'd0);
      ov_cnt0 += int'(bus0.overrun);
    end
    fclk = 1'b0;
    cycle(1'b0, 16'h0, 10'd7);
    ov_cnt0 += int'(bus0.overrun);
    check("t5_overrun", ov_cnt0, 0);
    check("t5_col7", bus0.next_val, 10'h0DA);
    cycle(1'b0, 16'h0, 10'd0);
    check("t5_col0", bus0.next_val, 10'h083);

    // tearing: sweep reads while the other bank fills
    for (int i = 0; i < 40; i++) cycle(1'(i % 2), 16'($urandom), 10'(i % 8));
    cycle(1'b0, 16'h0, 10'd9);
    check("t6_out_of_range", bus0.next_val, 10'd0);
    frame_pulse();
    for (int i = 0; i < 24; i++) cycle(1'b1, 16'($urandom), 10'(i % 10));

    // random traffic with free-running frame clock
    half = 0;
    left = 0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin
        fclk = ~fclk;
        left = $urandom_range(6, 30);
      end
      left--;
      cycle(1'($urandom_range(0, 9) < 7), 16'($urandom), 10'($urandom_range(0, 9)));
      if (i == 400) begin
        reset_mid();
        left = 0;
        half++;
      end
    end
    check("rand_reset_seen", half, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
